dct_transpose_buffer: RTL and testbench
=======================================

// Module: dct_transpose_buffer
// PURPOSE
//  Row-to-column transpose between the two passes of the 8x8 2-D DCT. Captures
//  eight consecutive 8-coefficient rows from the first-pass 1-D DCT and
//  re-emits the block column by column, one column per cycle, for the second pass.
//  Ping-pong storage (two 8x8 banks) lets the next block be written while the
//  previous one is read. Full input rate with no backpressure.
// PARAMETERS
//  DW  12  coefficient width (signed), input and output
// PORTS
//  i_clk               in   1     clock; all logic on rising edge
//  i_rst               in   1     synchronous reset, active-high
//  i_valid             in   1     row strobe; i_data0..7 valid this cycle
//  i_sync              in   1     with i_valid: this row is row 0 of a new block
//  i_data0..i_data7    in   DW    row coefficients, element index 0..7 (signed)
//  o_valid             out  1     column strobe
//  o_col               out  3     column index 0..7 of current output
//  o_first             out  1     o_valid && o_col==0
//  o_last              out  1     o_valid && o_col==7
//  o_data0..o_data7    out  DW    column: o_dataR = element[row R][col o_col]
//  o_err               out  1     sticky: partial block discarded by i_sync
// BEHAVIOUR
//  Reset: o_valid, o_col, o_first, o_last, o_data*, o_err = 0; write row ptr = 0;
//   write bank = 0; reader idle. Bank contents are not cleared.
//  Write side: on i_valid, store the row into write bank at row ptr, then ptr+1.
//   When the row at ptr 7 is stored, ptr wraps to 0, write bank toggles, and the
//   full bank is handed to the reader.
//  i_sync && i_valid: row stored as row 0 (ptr := 1). If ptr was nonzero, the
//   partial block is dropped, o_err set (cleared only by reset). i_sync with
//   i_valid=0 is ignored.
//  Read side FSM: IDLE -> STREAM on handoff. STREAM emits col 0..7 on 8
//   consecutive cycles, o_valid=1 throughout, no gaps. After col 7: back to
//   IDLE, or straight into col 0 of the next bank if a handoff is pending.
//  Latency: row 7 accepted at edge N -> col 0 registered at edge N+1 (visible
//   cycle N+1..N+2); col 7 at edge N+8.
//  Rate: input is at most 1 row/cycle, so a block needs >= 8 cycles and reading
//   a bank takes exactly 8. No overflow is possible. Back-to-back blocks produce
//   a continuous o_valid stream (64 rows -> 64 columns, no bubble).
//  Handoff on the cycle the reader finishes col 7 is legal; the next cycle is
//   col 0 of the new bank.
//  Data path is pure storage: no arithmetic, no rounding, no width change; sign
//   is preserved bit-exact.
//  Outputs are registered; o_data* hold their last value when o_valid=0.
//  Reset mid-operation: any in-flight output column is aborted and the partial
//   write block is discarded; o_valid is 0 on the cycle after reset is asserted.
// TESTING
//  1 Single block, rows r with elem c = 16*r+c, i_sync on row 0 ->
//    col k: o_dataR = 16*R+k, o_col 0..7, o_first at col 0, o_last at col 7,
//    col 0 one cycle after row 7.
//  2 Four blocks back-to-back (32 consecutive valid rows) -> 32 consecutive
//    o_valid cycles, correct transpose per block, no bubble between blocks.
//  3 Rows with gaps (i_valid 1 every 3 cycles) -> identical columns, 8
//    contiguous o_valid cycles per block.
//  4 Three rows then i_sync row -> o_err=1, first block output equals the block
//    started by the sync row; o_err stays 1 until reset.
//  5 Extremes: elements -2048 and +2047 -> passed bit-exact.
//  6 i_rst pulse during col 4 of streaming -> o_valid=0 next cycle, o_err=0;
//    fresh block afterwards transposes correctly.

Source files
------------

// File: rtl/dct_transpose_buffer.sv
// 8x8 row-to-column transpose between DCT passes, ping-pong banks; row 7 in at edge N -> col 0 out at edge N+1.
// No backpressure: accepts one row per cycle, emits eight contiguous columns per block.
module dct_transpose_buffer #(
  parameter int DW = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_sync,
  input  logic signed [DW-1:0] i_data0,
  input  logic signed [DW-1:0] i_data1,
  input  logic signed [DW-1:0] i_data2,
  input  logic signed [DW-1:0] i_data3,
  input  logic signed [DW-1:0] i_data4,
  input  logic signed [DW-1:0] i_data5,
  input  logic signed [DW-1:0] i_data6,
  input  logic signed [DW-1:0] i_data7,
  output logic                 o_valid,
  output logic [2:0]           o_col,
  output logic                 o_first,
  output logic                 o_last,
  output logic signed [DW-1:0] o_data0,
  output logic signed [DW-1:0] o_data1,
  output logic signed [DW-1:0] o_data2,
  output logic signed [DW-1:0] o_data3,
  output logic signed [DW-1:0] o_data4,
  output logic signed [DW-1:0] o_data5,
  output logic signed [DW-1:0] o_data6,
  output logic signed [DW-1:0] o_data7,
  output logic                 o_err
);

  typedef logic [7:0][DW-1:0] row_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  row_t       mem [2][8];
  row_t       in_row;
  row_t       out_dat_q;

  logic       wr_bank_q;
  logic [2:0] wr_ptr_q;
  logic       handoff_vld;
  logic       pend_vld_q;
  logic       pend_bank_q;
  logic       err_q;

  rd_state_t  rd_state_q, rd_state_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic       rd_bank_q, rd_bank_d;
  logic       rd_take;
  logic       emit_vld;
  logic       valid_q, first_q, last_q;

  assign in_row      = {i_data7, i_data6, i_data5, i_data4, i_data3, i_data2, i_data1, i_data0};
  // A sync row restarts the block, so it can never complete one.
  assign handoff_vld = i_valid && !i_sync && (wr_ptr_q == 3'd7);

  // Bank contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_valid && !i_rst) begin
      mem[wr_bank_q][i_sync ? 3'd0 : wr_ptr_q] <= in_row;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= 3'd0;
      wr_bank_q   <= 1'b0;
      err_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_bank_q <= 1'b0;
    end else begin
      if (i_valid) begin
        if (i_sync) begin
          if (wr_ptr_q != 3'd0) begin
            err_q <= 1'b1;
          end
          wr_ptr_q <= 3'd1;
        end else begin
          wr_ptr_q <= wr_ptr_q + 3'd1;
          if (wr_ptr_q == 3'd7) begin
            wr_bank_q <= ~wr_bank_q;
          end
        end
      end
      if (handoff_vld) begin
        pend_vld_q  <= 1'b1;
        pend_bank_q <= wr_bank_q;
      end else if (rd_take) begin
        pend_vld_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_col_d   = rd_col_q;
    rd_bank_d  = rd_bank_q;
    rd_take    = 1'b0;
    emit_vld   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (pend_vld_q) begin
          rd_take = 1'b1;
        end
      end
      RD_STREAM: begin
        if (rd_col_q != 3'd7) begin
          emit_vld = 1'b1;
          rd_col_d = rd_col_q + 3'd1;
        end else if (pend_vld_q) begin
          rd_take = 1'b1;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    // Starting a bank from either state: col 0 follows without a gap.
    if (rd_take) begin
      emit_vld   = 1'b1;
      rd_state_d = RD_STREAM;
      rd_col_d   = 3'd0;
      rd_bank_d  = pend_bank_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state_q <= RD_IDLE;
      rd_col_q   <= 3'd0;
      rd_bank_q  <= 1'b0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_col_q   <= rd_col_d;
      rd_bank_q  <= rd_bank_d;
      valid_q    <= emit_vld;
      first_q    <= emit_vld && (rd_col_d == 3'd0);
      last_q     <= emit_vld && (rd_col_d == 3'd7);
      if (emit_vld) begin
        for (int r = 0; r < 8; r++) begin
          out_dat_q[r] <= mem[rd_bank_d][r][rd_col_d];
        end
      end
    end
  end

  assign o_valid = valid_q;
  assign o_col   = rd_col_q;
  assign o_first = first_q;
  assign o_last  = last_q;
  assign o_err   = err_q;
  assign o_data0 = out_dat_q[0];
  assign o_data1 = out_dat_q[1];
  assign o_data2 = out_dat_q[2];
  assign o_data3 = out_dat_q[3];
  assign o_data4 = out_dat_q[4];
  assign o_data5 = out_dat_q[5];
  assign o_data6 = out_dat_q[6];
  assign o_data7 = out_dat_q[7];

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Randomized bench for dct_transpose_buffer against a block-level transpose model.
// Expected columns are scheduled per clock edge from completed blocks.
module tb_dct_transpose_buffer;
  localparam int DW   = 12;
  localparam int MAXC = 4096;

  typedef logic [7:0][DW-1:0] row_t;

  logic                 i_clk = 1'b0;
  logic                 i_rst, i_valid, i_sync;
  logic signed [DW-1:0] i_data0, i_data1, i_data2, i_data3, i_data4, i_data5, i_data6, i_data7;
  logic                 o_valid, o_first, o_last, o_err;
  logic [2:0]           o_col;
  logic signed [DW-1:0] o_data0, o_data1, o_data2, o_data3, o_data4, o_data5, o_data6, o_data7;

  dct_transpose_buffer #(.DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sync(i_sync),
    .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2), .i_data3(i_data3),
    .i_data4(i_data4), .i_data5(i_data5), .i_data6(i_data6), .i_data7(i_data7),
    .o_valid(o_valid), .o_col(o_col), .o_first(o_first), .o_last(o_last),
    .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2), .o_data3(o_data3),
    .o_data4(o_data4), .o_data5(o_data5), .o_data6(o_data6), .o_data7(o_data7),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: the block under construction plus a per-edge output schedule.
  row_t [7:0] m_blk;
  int         m_ptr  = 0;
  bit         m_err  = 1'b0;
  int         m_free = 0;
  row_t       m_last = '0;
  bit         exp_v [MAXC];
  logic [2:0] exp_c [MAXC];
  row_t       exp_d [MAXC];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, want);
    end
  endtask

  // Block complete at edge e: columns follow from e+1, or right after the previous block.
  task automatic model_handoff(input int e);
    int start;
    start = (e + 1 > m_free) ? e + 1 : m_free;
    for (int k = 0; k < 8; k++) begin
      if (start + k < MAXC) begin
        exp_v[start+k] = 1'b1;
        exp_c[start+k] = 3'(k);
        for (int r = 0; r < 8; r++) exp_d[start+k][r] = m_blk[r][k];
      end
    end
    m_free = start + 8;
  endtask

  task automatic model_edge(input bit rst, input bit v, input bit s, input row_t row);
    if (rst) begin
      m_ptr  = 0;
      m_err  = 1'b0;
      m_free = 0;
      m_last = '0;
      for (int i = cyc; i < MAXC; i++) exp_v[i] = 1'b0;
    end else if (v) begin
      if (s) begin
        if (m_ptr != 0) m_err = 1'b1;
        m_blk[0] = row;
        m_ptr    = 1;
      end else begin
        m_blk[m_ptr] = row;
        m_ptr++;
        if (m_ptr == 8) begin
          m_ptr = 0;
          model_handoff(cyc);
        end
      end
    end
  endtask

  task automatic check_outputs();
    row_t got;
    got = {o_data7, o_data6, o_data5, o_data4, o_data3, o_data2, o_data1, o_data0};
    chk("o_valid", 128'(o_valid), 128'(exp_v[cyc]));
    chk("o_err", 128'(o_err), 128'(m_err));
    if (exp_v[cyc]) begin
      chk("o_col", 128'(o_col), 128'(exp_c[cyc]));
      chk("o_first", 128'(o_first), 128'(exp_c[cyc] == 3'd0));
      chk("o_last", 128'(o_last), 128'(exp_c[cyc] == 3'd7));
      chk("o_data", 128'(got), 128'(exp_d[cyc]));
      m_last = exp_d[cyc];
    end else begin
      chk("o_first_idle", 128'(o_first), 128'(0));
      chk("o_last_idle", 128'(o_last), 128'(0));
      chk("o_data_hold", 128'(got), 128'(m_last));
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit s, input row_t row);
    i_rst   = rst;
    i_valid = v;
    i_sync  = s;
    {i_data7, i_data6, i_data5, i_data4, i_data3, i_data2, i_data1, i_data0} = row;
    @(posedge i_clk);
    cyc++;
    model_edge(rst, v, s, row);
    #1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d limit %0d", cyc, MAXC);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "cycle budget exhausted");
    end
    check_outputs();
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int c = 0; c < 8; c++) r[c] = DW'($urandom);
    return r;
  endfunction

  function automatic row_t ramp_row(input int r);
    row_t x;
    for (int c = 0; c < 8; c++) x[c] = DW'(16 * r + c);
    return x;
  endfunction

  function automatic row_t extreme_row();
    row_t x;
    for (int c = 0; c < 8; c++) x[c] = ($urandom_range(0, 1) == 1) ? 12'h800 : 12'h7FF;
    return x;
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, rand_row());
  endtask

  // kind: 0 random, 1 ramp 16*r+c, 2 extremes
  task automatic send_block(input int kind, input int gap, input bit sync0);
    row_t row;
    for (int r = 0; r < 8; r++) begin
      case (kind)
        1:       row = ramp_row(r);
        2:       row = extreme_row();
        default: row = rand_row();
      endcase
      step(1'b0, 1'b1, sync0 && (r == 0), row);
      if (r != 7) idle(gap);
    end
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, rand_row());

    send_block(1, 0, 1'b1);
    idle(10);

    repeat (4) send_block(0, 0, 1'b1);
    idle(10);

    repeat (2) send_block(0, 2, 1'b1);
    idle(10);

    step(1'b0, 1'b1, 1'b1, rand_row());
    step(1'b0, 1'b1, 1'b0, rand_row());
    step(1'b0, 1'b1, 1'b0, rand_row());
    send_block(0, 0, 1'b1);
    idle(10);
    send_block(0, 1, 1'b0);
    idle(10);

    step(1'b1, 1'b0, 1'b0, rand_row());
    repeat (2) send_block(2, 0, 1'b1);
    idle(10);

    send_block(0, 0, 1'b1);
    idle(5);
    step(1'b1, 1'b1, 1'b0, rand_row());
    idle(2);
    send_block(1, 0, 1'b1);
    idle(10);

    for (int i = 0; i < 600; i++) begin
      bit v, s, rst;
      v   = ($urandom_range(0, 3) != 0);
      s   = v && ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, v, s, rand_row());
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
